// File: rtl/dl_shift_iter_if.sv
// Request/response bundle for the iterative shift unit.
// The requester/consumer side uses master; the shift unit uses slave.
interface dl_shift_iter_if #(
  parameter int NUM_BITS = 32
);
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

  logic                      req_val;
  logic                      req_rdy;
  logic [1:0]                req_op;
  logic [NUM_BITS-1:0]       req_data;
  logic [NUM_SHIFT_BITS-1:0] req_shamt;
  logic                      resp_val;
  logic                      resp_rdy;
  logic [NUM_BITS-1:0]       resp_data;
  logic                      busy;

  modport master (
    output req_val, req_op, req_data, req_shamt, resp_rdy,
    input  req_rdy, resp_val, resp_data, busy
  );

  modport slave (
    input  req_val, req_op, req_data, req_shamt, resp_rdy,
    output req_rdy, resp_val, resp_data, busy
  );
endinterface

// File: rtl/dl_shift_iter.sv
// Iterative shifter: applies at most STEP positions per cycle until the
// requested amount is consumed, then holds the result until it is taken.
module dl_shift_iter #(
  parameter int NUM_BITS = 32,
  parameter int STEP     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dl_shift_iter_if.slave bus
);
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;

  // STEP may equal NUM_BITS, which needs one extra bit to compare against rem.
  localparam logic [NUM_SHIFT_BITS:0]   STEP_W = (NUM_SHIFT_BITS + 1)'(STEP);
  // Only used when rem > STEP, which implies STEP < NUM_BITS.
  localparam logic [NUM_SHIFT_BITS-1:0] STEP_T = NUM_SHIFT_BITS'(STEP % NUM_BITS);

  logic [1:0]                state, state_nxt;
  logic [NUM_BITS-1:0]       acc, acc_nxt;
  logic [NUM_SHIFT_BITS-1:0] rem, rem_nxt;
  logic [1:0]                op, op_nxt;

  logic                      last;
  logic [NUM_SHIFT_BITS:0]   step;
  logic [NUM_BITS-1:0]       shifted;
  logic                      accept;

  assign last   = ({1'b0, rem} <= STEP_W);
  assign step   = last ? {1'b0, rem} : STEP_W;
  assign accept = bus.req_val && (state == ST_IDLE);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    shifted = acc >> step;
    case (op)
      OP_SLL:  shifted = acc << step;
      OP_SRA:  shifted = $unsigned($signed(acc) >>> step);
      default: shifted = acc >> step;
    endcase
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    op_nxt    = op;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          acc_nxt   = bus.req_data;
          rem_nxt   = bus.req_shamt;
          op_nxt    = bus.req_op;
          state_nxt = (bus.req_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_nxt = shifted;
        if (last) begin
          rem_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          rem_nxt = rem - STEP_T;
        end
      end
      ST_DONE: begin
        if (bus.resp_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: acc is reset along with the control state so resp_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      rem   <= '0;
      op    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      op    <= op_nxt;
    end
  end

  assign bus.req_rdy   = (state == ST_IDLE);
  assign bus.resp_val  = (state == ST_DONE);
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.resp_data = acc;
endmodule
